// File: rtl/pulse_width_tracer_if.sv
// Signal bundle between a pulse_width_tracer and the logic driving its strobe
// inputs and consuming its per-channel classification results.
interface pulse_width_tracer_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 1
);
  logic                      en;
  logic [CHANNELS-1:0]       noisy_in;
  logic [CHANNELS-1:0]       pulse_detected;
  logic [CHANNELS-1:0]       pulse_rejected;
  logic [CHANNELS*CNT_W-1:0] pulse_width;

  modport master (
    output en, noisy_in,
    input  pulse_detected, pulse_rejected, pulse_width
  );

  modport slave (
    input  en, noisy_in,
    output pulse_detected, pulse_rejected, pulse_width
  );
endinterface

// File: rtl/pulse_width_tracer.sv
// Per-channel high-run classifier: each completed run is reported as accepted
// (with its width) or rejected against the window [MIN_WIDTH, MAX_WIDTH].
module pulse_width_tracer #(
  parameter int CHANNELS  = 4,
  parameter int MIN_WIDTH = 1,
  parameter int MAX_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_width_tracer_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_WIDTH + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

  typedef enum logic [1:0] {ARM, IDLE, HIGH, LONG} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == MAX_C) ? c : c + CNT_W'(1);
  endfunction

  state_t                    state_p0 [CHANNELS];
  state_t                    state_d  [CHANNELS];
  logic [CNT_W-1:0]          cnt_p0   [CHANNELS];
  logic [CNT_W-1:0]          cnt_d    [CHANNELS];
  logic [CHANNELS-1:0]       det_p1, det_d;
  logic [CHANNELS-1:0]       rej_p1, rej_d;
  logic [CHANNELS*CNT_W-1:0] wid_p1, wid_d;

  // Stage 0: per-channel FSM and run counter, sampling noisy_in directly
  always_comb begin
    det_d = '0;
    rej_d = '0;
    wid_d = wid_p1;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_p0[i];
      cnt_d[i]   = cnt_p0[i];
      if (!bus.en) begin
        state_d[i] = ARM;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_p0[i])
          ARM: begin
            if (!bus.noisy_in[i]) state_d[i] = IDLE;
          end
          IDLE: begin
            if (bus.noisy_in[i]) begin
              state_d[i] = HIGH;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          HIGH: begin
            if (bus.noisy_in[i]) begin
              // At the ceiling the counter holds and the run is already too long
              if (cnt_p0[i] == MAX_C) state_d[i] = LONG;
              else                    cnt_d[i]   = sat_inc(cnt_p0[i]);
            end else begin
              state_d[i] = IDLE;
              if (cnt_p0[i] >= MIN_C) begin
                det_d[i]                  = 1'b1;
                wid_d[i*CNT_W +: CNT_W]   = cnt_p0[i];
              end else begin
                rej_d[i] = 1'b1;
              end
            end
          end
          LONG: begin
            if (!bus.noisy_in[i]) begin
              state_d[i] = IDLE;
              rej_d[i]   = 1'b1;
            end
          end
          default: state_d[i] = ARM;
        endcase
      end
    end
  end

  // Stage 1: registered strobes and accepted widths
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_p0[i] <= ARM;
        cnt_p0[i]   <= '0;
      end
      det_p1 <= '0;
      rej_p1 <= '0;
      wid_p1 <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_p0[i] <= state_d[i];
        cnt_p0[i]   <= cnt_d[i];
      end
      det_p1 <= det_d;
      rej_p1 <= rej_d;
      wid_p1 <= wid_d;
    end
  end

  assign bus.pulse_detected = det_p1;
  assign bus.pulse_rejected = rej_p1;
  assign bus.pulse_width    = wid_p1;
endmodule

// File: doc/pulse_width_tracer.md
# pulse_width_tracer

Multi-channel, parametrised pulse classifier. It generalises single-pulse detection to CHANNELS independent inputs, with a programmable accepted width window [MIN_WIDTH, MAX_WIDTH]. For every completed high run it reports either acceptance (with the measured width) or rejection. It sits directly behind raw or noisy strobe inputs and feeds event logic that needs only well-formed pulses.

## Interface
- CHANNELS, 4: number of independent input channels (>= 1).
- MIN_WIDTH, 1: shortest accepted high run, in clk cycles (>= 1).
- MAX_WIDTH, 1: longest accepted high run, in clk cycles (>= MIN_WIDTH). The defaults accept exactly one-cycle pulses.
- CNT_W, derived localparam, $clog2(MAX_WIDTH+1): width of the per-channel width field.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low forces every channel to ARM.
- noisy_in  in  CHANNELS  raw inputs; bit i is channel i, sampled directly at each clk edge.
- pulse_detected  out  CHANNELS  one-cycle strobe; channel's last run was within the window.
- pulse_rejected  out  CHANNELS  one-cycle strobe; channel's last run was outside the window.
- pulse_width  out  CHANNELS*CNT_W  last accepted width per channel; channel i at [i*CNT_W +: CNT_W].

## Operation
- A "run" is N >= 1 consecutive sampled 1s, preceded by a sampled 0 and terminated by a sampled 0.
- Each channel has its own FSM (ARM, IDLE, HIGH, LONG) and its own saturating run counter (CNT_W bits).
- ARM: entered on reset or when en=0. Sampled 0 with en=1 -> IDLE. Sampled 1 stays in ARM, so a run already in progress is never reported.
- IDLE, sampled 1 -> HIGH, cnt=1.
- HIGH, sampled 1, cnt<MAX_WIDTH -> cnt+1.
- HIGH, sampled 1, cnt==MAX_WIDTH -> LONG; the counter holds.
- HIGH, sampled 0 -> IDLE.
  - If cnt>=MIN_WIDTH: assert pulse_detected and load pulse_width with cnt.
  - Otherwise: assert pulse_rejected; pulse_width is unchanged.
- LONG, sampled 1 -> stays in LONG.
- LONG, sampled 0 -> IDLE, pulse_rejected asserted, pulse_width unchanged.
- At most one of pulse_detected[i] and pulse_rejected[i] is high in any cycle. The channels are fully independent, so simultaneous strobes on several channels are legal.
- A run's outcome depends only on its total length. Runs longer than MAX_WIDTH are not reported until they terminate.
- Priority: rst over en over normal operation.
- en=0 also clears the strobes next cycle. pulse_width holds its value through en=0.

## Timing
- Reset values: pulse_detected=0, pulse_rejected=0, pulse_width=0, all FSMs in ARM, counters 0.
- Latency: the strobe is registered. It is high for exactly the one clock cycle following the rising edge at which the terminating 0 is sampled.
- pulse_width updates on that same edge, coincident with pulse_detected.
- Back-to-back runs separated by a single sampled 0 are each classified; minimum event spacing is 2 cycles per channel.
- Reset mid-run: the channel goes to ARM, the in-flight run is discarded, and its eventual falling edge produces no strobe.
- en deasserted mid-run: same as reset for the FSM, but pulse_width is kept.
- Input sampled high while rst or en is asserted, then released: no strobe until a 0 has been sampled.

## Test plan
- Reset: rst=1 for 2 cycles with arbitrary noisy_in -> all strobes 0, pulse_width=0 for the next cycle and beyond while inputs stay low.
- Defaults (CHANNELS=1, MIN=MAX=1): 1-cycle pulse -> pulse_detected=1 for one cycle, pulse_width=1. 2-cycle pulse -> pulse_rejected=1 for one cycle, pulse_width stays 1.
- CHANNELS=4, MIN=2, MAX=4: ch0 high 3 cycles -> pulse_detected=4'b0001 one cycle after the falling sample, ch0 width=3. ch1 high 1 cycle -> pulse_rejected=4'b0010, ch1 width stays 0.
- Same config: ch2 high 7 cycles -> no strobe during the run, pulse_rejected=4'b0100 only after termination. ch0 high 2 cycles and ch3 high 4 cycles ending on the same edge -> pulse_detected=4'b1001 in the same cycle, widths 2 and 4.
- Same config: ch0 held high across reset release, falls 5 cycles later -> no strobe. Next 2-cycle pulse -> detected, width=2.
- Same config: rst asserted in cycle 2 of a 3-cycle ch1 run -> no strobe. en=0 for 1 cycle mid-run on ch0 -> no strobe, previous ch0 width retained.
